// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, wait for trigger, write 2^ADDR_W samples to BRAM, report done.
// Optional trigger offset (discard the first N qualified samples) enabled by SNAP_TRIG_OFFSET_EN.
module snap_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ext_trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             arm_q;
  logic             arm_edge_c;
  logic             qual_c;
  logic             take_c;
  logic             trig_c;
  logic             wr_c;
  logic [31:0]      status_nxt;
  logic             unused_ctrl;

`ifdef SNAP_TRIG_OFFSET_EN
  logic [15:0] dly, dly_nxt, dly_eff;
`endif

  assign unused_ctrl = ^ctrl_in[31:3];

  // State register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, write qualification and count update
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    take_c     = 1'b0;
    trig_c     = 1'b0;
    wr_c       = 1'b0;
    arm_edge_c = ctrl_in[0] & ~arm_q;
    qual_c     = ctrl_in[2] | din_valid;
`ifdef SNAP_TRIG_OFFSET_EN
    dly_nxt    = dly;
    dly_eff    = dly;
`endif

    case (state)
      ARMED: begin
        // An arm edge outranks a trigger arriving in the same cycle
        if (!arm_edge_c && (ctrl_in[1] || ext_trig)) begin
          trig_c    = 1'b1;
          take_c    = qual_c;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: take_c = qual_c;
      default: ;
    endcase

`ifdef SNAP_TRIG_OFFSET_EN
    if (trig_c) begin
      dly_eff = ctrl_in[31:16];
      dly_nxt = ctrl_in[31:16];
    end
    if (take_c) begin
      if (dly_eff != 16'd0) begin
        dly_nxt = dly_eff - 16'd1;
      end else begin
        wr_c = 1'b1;
      end
    end
`else
    wr_c = take_c;
`endif

    if (wr_c) begin
      count_nxt = count + CNT_W'(1);
      if (count_nxt == CNT_FULL) begin
        state_nxt = DONE;
      end
    end

    // A qualified sample in the arm-edge cycle is still written; the restart wins the state
    if (arm_edge_c) begin
      state_nxt = ARMED;
      count_nxt = '0;
    end

    status_nxt             = '0;
    status_nxt[31]         = (state_nxt == DONE);
    status_nxt[30]         = (state_nxt == ARMED);
    status_nxt[29]         = (state_nxt == CAPTURE);
    status_nxt[ADDR_W:0]   = count_nxt;
  end

  // Datapath: write port, counters and status readback
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      arm_q      <= 1'b0;
      count      <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      status_out <= '0;
`ifdef SNAP_TRIG_OFFSET_EN
      dly        <= '0;
`endif
    end else begin
      arm_q      <= ctrl_in[0];
      count      <= count_nxt;
      bram_we    <= wr_c;
      status_out <= status_nxt;
      if (wr_c) begin
        bram_addr <= count[ADDR_W-1:0];
        bram_data <= din;
      end
`ifdef SNAP_TRIG_OFFSET_EN
      dly        <= dly_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl (ADDR_W=4) with a write scoreboard.
module tb_snap_capture_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
`ifdef SNAP_TRIG_OFFSET_EN
  localparam int OFF = 3;
`else
  localparam int OFF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       ctrl;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status_out;

  int passed = 0;
  int total  = 0;
  bit mon_en = 1'b0;
  logic [ADDR_W+DATA_W-1:0] sb[$];

  snap_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk   (clk),
    .user_rst   (rst),
    .ctrl_in    (ctrl),
    .din        (din),
    .din_valid  (din_valid),
    .ext_trig   (ext_trig),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [DATA_W-1:0] data);
    sb.push_back({ADDR_W'(addr), data});
  endtask

  // Every BRAM write must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && bram_we === 1'b1) begin
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", bram_addr, bram_data);
      if (sb.size() != 0) chk("write", 64'({bram_addr, bram_data}), 64'(sb.pop_front()));
    end
  end

  initial begin
    int wcount;
    int writes;
    int j;
    rst = 1'b1; ctrl = '0; din = '0; din_valid = 1'b0; ext_trig = 1'b0;
    tick(); tick();
    chk("rst_status", 64'(status_out), 64'h0);
    chk("rst_we", 64'(bram_we), 64'h0);
    chk("rst_addr", 64'(bram_addr), 64'h0);
    chk("rst_data", 64'(bram_data), 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Immediate trigger, valid-gated full capture
    tick();
    ctrl = 32'h3; din = 32'hFF; din_valid = 1'b1;
    tick();
    chk("t1_armed", 64'(status_out), 64'h4000_0000);
    for (int i = 0; i < 16; i++) begin
      din = 32'h100 + 32'(i);
      push(i, din);
      tick();
      chk("t1_status", 64'(status_out), (i == 15) ? 64'h8000_0010 : 64'(32'h2000_0000 | 32'(i + 1)));
    end

    // Level held high must not re-arm
    for (int i = 0; i < 100; i++) tick();
    chk("t2_done_hold", 64'(status_out), 64'h8000_0010);
    chk("t2_we_idle", 64'(bram_we), 64'h0);
    ctrl = 32'h0;
    tick();
    chk("t2_done_low", 64'(status_out), 64'h8000_0010);

    // Re-arm with external trigger, valid toggling
    ctrl = 32'h1; din_valid = 1'b0;
    tick();
    chk("t3_rearm", 64'(status_out), 64'h4000_0000);
    for (int k = 0; k < 20; k++) begin
      din_valid = ~k[0];
      din = 32'h1F0 + 32'(k);
      tick();
      chk("t3_wait_armed", 64'(status_out), 64'h4000_0000);
    end
    ext_trig = 1'b1; din_valid = 1'b1; din = 32'h200;
    push(0, din);
    tick();
    chk("t3_trig", 64'(status_out), 64'h2000_0001);
    wcount = 1;
    ext_trig = 1'b0;
    for (int m = 0; m < 12; m++) begin
      din_valid = m[0];
      din = 32'h201 + 32'(m);
      if (din_valid) begin
        push(wcount, din);
        wcount++;
      end
      tick();
      chk("t3_gated", 64'(status_out), 64'(32'h2000_0000 | 32'(wcount)));
    end

    // Arm edge after 7 writes restarts the capture
    ctrl = 32'h0; din_valid = 1'b0;
    tick();
    chk("t4_seven", 64'(status_out), 64'h2000_0007);
    ctrl = 32'h1;
    tick();
    chk("t4_abort", 64'(status_out), 64'h4000_0000);
    ctrl = 32'h0;
    tick();
    // Arm edge coincident with ext_trig: arm wins, no write
    ctrl = 32'h1; ext_trig = 1'b1; din_valid = 1'b1; din = 32'hDEAD;
    tick();
    chk("t4_arm_vs_trig", 64'(status_out), 64'h4000_0000);
    ext_trig = 1'b0;
    tick();
    chk("t4_still_armed", 64'(status_out), 64'h4000_0000);
    ext_trig = 1'b1; din = 32'h300;
    push(0, din);
    tick();
    chk("t4_addr0", 64'(status_out), 64'h2000_0001);
    ext_trig = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 32'h301 + 32'(k);
      push(k + 1, din);
      tick();
      chk("t4_count", 64'(status_out), 64'(32'h2000_0002 + 32'(k)));
    end

    // Reset mid-capture: all outputs clear, no further writes
    rst = 1'b1; ctrl = 32'h0; din = 32'h3FF;
    tick();
    chk("t5_rst_we", 64'(bram_we), 64'h0);
    chk("t5_rst_addr", 64'(bram_addr), 64'h0);
    chk("t5_rst_data", 64'(bram_data), 64'h0);
    chk("t5_rst_status", 64'(status_out), 64'h0);
    rst = 1'b0;
    tick();
    chk("t5_idle", 64'(status_out), 64'h0);

    // Every-cycle mode with offset field set, final write coincident with an arm edge
    ctrl = 32'h0003_0007; din_valid = 1'b0; din = 32'hAA;
    tick();
    chk("t6_armed", 64'(status_out), 64'h4000_0000);
    writes = 0;
    j = 0;
    while (writes < 16) begin
      din = 32'(j);
      ctrl = (j == OFF + 14) ? 32'h0003_0006 : 32'h0003_0007;
      if (j >= OFF) begin
        push(j - OFF, din);
        writes++;
      end
      tick();
      chk("t6_status", 64'(status_out),
          (j == OFF + 15) ? 64'h4000_0000 : 64'(32'h2000_0000 | 32'(writes)));
      j++;
    end
    ctrl = 32'h0003_0005;
    tick();
    chk("t6_rearmed_hold", 64'(status_out), 64'h4000_0000);
    tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
